imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a byte-stream program image and writes 16-bit instruction words into instruction memory at sequential 6-bit addresses.
- Holds the processor stalled (`cpu_run` low) until a complete image has loaded and its checksum matches.
- Sits between the host/debug byte link and the instruction memory write port, next to the datapath's PC/fetch logic.

Parameters:
- ADDR_W, 6, instruction memory address width (matches the 6-bit PC).
- DEPTH, 64, maximum words per image (2**ADDR_W).
- DATA_W, 16, instruction word width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clear_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR; ignored elsewhere.
- byte_valid  in  1  host presents `byte_data`.
- byte_data  in  8  image byte.
- byte_ready  out  1  loader can accept a byte this cycle.
- im_we  out  1  instruction memory write enable, one-cycle pulse per word.
- im_addr  out  ADDR_W  write address.
- im_wdata  out  DATA_W  write data.
- busy  out  1  load in progress.
- done  out  1  last load succeeded; sticky until `start` or reset.
- error  out  1  last load failed; sticky until `start` or reset.
- cpu_run  out  1  release to processor PC/regfile; equals `done`.

Behaviour:
- Reset (async, clear_n=0): state=IDLE. All outputs 0: `byte_ready`, `im_we`, `im_addr`, `im_wdata`, `busy`, `done`, `error`, `cpu_run`. Word counter, length register, checksum and high-byte register also 0.
- Byte transfer occurs only on a clock edge with `byte_valid`=1 and `byte_ready`=1. `byte_data` is sampled on that edge. `byte_valid` without `byte_ready` is ignored. The host may hold `byte_valid` high continuously.
- Image format, in order:
  - LEN byte N, range 1..DEPTH.
  - N words, each sent high byte then low byte.
  - CSUM byte equal to the XOR of all 2N word bytes (LEN is excluded).
- States:
  - IDLE: `byte_ready`=0. On `start`: clear counter, checksum, `done` and `error`; set `busy`=1; go to LEN.
  - LEN: `byte_ready`=1. On transfer:
    - If byte=0 or byte>DEPTH, go to ERR.
    - Otherwise store N and go to HI.
  - HI: `byte_ready`=1. On transfer, latch the high byte, XOR it into the checksum, go to LO.
  - LO: `byte_ready`=1. On transfer:
    - `im_wdata` <= {hi,byte}; `im_addr` <= counter; XOR the byte into the checksum.
    - Go to WRITE.
  - WRITE: `byte_ready`=0. `im_we`=1 for exactly this one cycle, with `im_addr` and `im_wdata` stable. Counter increments. If the incremented count equals N, go to CSUM, else go to HI.
  - CSUM: `byte_ready`=1. On transfer, go to DONE if the byte equals the checksum, else go to ERR.
  - DONE: `busy`=0, `done`=1, `cpu_run`=1, `byte_ready`=0.
  - ERR: `busy`=0, `error`=1, `cpu_run`=0, `byte_ready`=0.
- Timing and throughput:
  - Word throughput is at most one word per 3 cycles (HI, LO, WRITE).
  - Latency from the accepted LO byte to the `im_we` pulse is 1 cycle.
- Counter width is ADDR_W+1 so that N=64 terminates correctly. `im_addr` is the low ADDR_W bits and never wraps within a load. The last write of N=64 is to address 63.
- `im_addr` and `im_wdata` hold their last values outside WRITE. `im_we`=0 in every state except WRITE.
- `start` in LEN, HI, LO, WRITE or CSUM is ignored: there is no restart mid-load.
- Reset mid-load aborts immediately, with no further `im_we`. Words already written remain in memory; `cpu_run`=0.
- A new `start` from DONE drops `cpu_run` on the next edge, before any byte is accepted.
- `done` and `error` are never both 1.

Test Plan:
- Nominal load: pulse `start`, then send bytes 0x02, 0x12, 0x34, 0xAB, 0xCD, CSUM=0x12^0x34^0xAB^0xCD=0x40 -> exactly two writes: (0x00, 0x1234) then (0x01, 0xABCD), each `im_we` 1 cycle wide; then `done`=`cpu_run`=1, `busy`=0.
- Bad checksum: same image with CSUM 0x41 -> both words written, then `error`=1, `done`=0, `cpu_run`=0.
- Illegal length: LEN 0x00 and, separately, LEN 0x41 -> ERR immediately with no `im_we` pulse; LEN 0x40 (full 64 words, data=address) -> last write is (0x3F, 0x003F), then DONE.
- Backpressure/stall: `byte_valid` held high continuously -> `byte_ready` low during WRITE; each byte is consumed exactly once and words match a byte-gapped run with random valid gaps.
- Reset mid-load: assert `clear_n`=0 after 3 of 5 words -> all outputs 0 asynchronously with no further writes; after `start` plus a fresh image, normal completion.
- Reload and ignored start: `start` during HI is ignored and the load completes normally; `start` from DONE drops `cpu_run` the next cycle, and a second image loads and overwrites from address 0.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte link from the host plus the instruction-memory write port of the loader.
// Handshake: a byte moves on a rising edge only when byte_valid and byte_ready are both 1;
// byte_valid may stay high indefinitely and byte_ready never depends on byte_valid.
interface imem_loader_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [DATA_W-1:0] im_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a LEN / hi-lo word pairs / XOR checksum byte image into instruction memory
// and keeps the CPU stalled until a complete image has been written and verified.
module imem_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 1 << ADDR_W,
  parameter int DATA_W = 16
) (
  input  logic               clk,
  input  logic               clear_n,
  input  logic               start,
  imem_loader_if.slave       bus,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               cpu_run,
  output logic [2:0]         state_dbg
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_HI    = 3'd2;
  localparam logic [2:0] S_LO    = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_CSUM  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  localparam logic [8:0] DEPTH_B = 9'(DEPTH);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic            byte_ready;
  logic            xfer;
  logic [ADDR_W:0] cnt_inc;

  assign byte_ready = (state_q == S_LEN) || (state_q == S_HI) ||
                      (state_q == S_LO)  || (state_q == S_CSUM);
  assign xfer       = bus.byte_valid && byte_ready;
  assign cnt_inc    = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    csum_d  = csum_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          cnt_d   = '0;
          csum_d  = '0;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (xfer) begin
          if (bus.byte_data == 8'd0 || {1'b0, bus.byte_data} > DEPTH_B) begin
            state_d = S_ERR;
          end else begin
            len_d   = bus.byte_data[ADDR_W:0];
            state_d = S_HI;
          end
        end
      end
      S_HI: begin
        if (xfer) begin
          hi_d    = bus.byte_data;
          csum_d  = csum_q ^ bus.byte_data;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (xfer) begin
          wdata_d = {hi_q, bus.byte_data};
          addr_d  = cnt_q[ADDR_W-1:0];
          csum_d  = csum_q ^ bus.byte_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // Counter is one bit wider than the address so a full-depth image still terminates.
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == len_q) ? S_CSUM : S_HI;
      end
      S_CSUM: begin
        if (xfer) begin
          state_d = (bus.byte_data == csum_q) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      csum_q  <= '0;
      hi_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      csum_q  <= csum_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.byte_ready = byte_ready;
  assign bus.im_we      = (state_q == S_WRITE);
  assign bus.im_addr    = addr_q;
  assign bus.im_wdata   = wdata_q;
  assign busy           = byte_ready || (state_q == S_WRITE);
  assign done           = (state_q == S_DONE);
  assign error          = (state_q == S_ERR);
  assign cpu_run        = (state_q == S_DONE);
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: images are built from word lists, expected memory
// writes are queued as each image is issued and a negedge monitor retires them.
module tb_imem_loader;

  logic       clk;
  logic       clear_n;
  logic       start;
  logic       busy, done, error, cpu_run;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  logic [21:0] exp_q[$];

  imem_loader_if #(.ADDR_W(6), .DATA_W(16)) bus ();

  imem_loader #(.ADDR_W(6), .DEPTH(64), .DATA_W(16)) dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .start     (start),
    .bus       (bus.slave),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .cpu_run   (cpu_run),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  logic prev_we = 1'b0;
  always @(negedge clk) begin
    logic [21:0] e;
    if (clear_n) begin
      if (bus.im_we) begin
        chk("we_one_cycle", 32'(prev_we), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", 32'(bus.im_addr), 32'(e[21:16]));
          chk("write_data", 32'(bus.im_wdata), 32'(e[15:0]));
        end
      end
      if (done || error) chk("done_error_excl", 32'(done && error), 32'd0);
      prev_we = bus.im_we;
    end else begin
      prev_we = 1'b0;
    end
  end

  // driver tasks: entered and left just after a rising edge
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int g;
    int n;
    g = $urandom_range(0, max_gap);
    if (g > 0) begin
      bus.byte_valid = 1'b0;
      repeat (g) @(posedge clk);
      #1;
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (bus.byte_ready) break;
      n++;
      if (n > 100) begin
        chk("byte_ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_end(input bit exp_ok, input bit have_words,
                           input logic [5:0] last_addr, input logic [15:0] last_data);
    @(negedge clk);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_done", 32'(done), 32'(exp_ok));
    chk("end_error", 32'(error), 32'(!exp_ok));
    chk("end_cpu_run", 32'(cpu_run), 32'(exp_ok));
    chk("end_byte_ready", 32'(bus.byte_ready), 32'd0);
    chk("end_pending_writes", 32'(exp_q.size()), 32'd0);
    if (have_words) begin
      chk("hold_addr", 32'(bus.im_addr), 32'(last_addr));
      chk("hold_data", 32'(bus.im_wdata), 32'(last_data));
    end
  endtask

  // Reference model: image bytes and expected writes derived from the word list.
  task automatic run_image(input logic [15:0] words[$], input logic [7:0] len_byte,
                           input bit corrupt, input int max_gap, input bit start_in_hi);
    logic [7:0] cs;
    int n;
    n = int'(len_byte);
    send_byte(len_byte, max_gap);
    if (n == 0 || n > 64) begin
      bus.byte_valid = 1'b0;
      check_end(1'b0, 1'b0, 6'd0, 16'd0);
      return;
    end
    if (start_in_hi) begin
      bus.byte_valid = 1'b0;
      pulse_start();
      @(negedge clk);
      chk("start_in_hi_busy", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
    end
    cs = 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({6'(i), words[i]});
      cs = cs ^ words[i][15:8] ^ words[i][7:0];
      send_byte(words[i][15:8], max_gap);
      send_byte(words[i][7:0], max_gap);
    end
    send_byte(corrupt ? (cs ^ 8'h01) : cs, max_gap);
    bus.byte_valid = 1'b0;
    check_end(!corrupt, 1'b1, 6'(n - 1), words[n - 1]);
  endtask

  function automatic void rand_words(output logic [15:0] w[$], input int n);
    w = {};
    for (int i = 0; i < n; i++) w.push_back(16'($urandom_range(0, 16'hFFFF)));
  endfunction

  initial begin
    logic [15:0] w[$];
    int n;
    bit bad;
    clear_n        = 1'b0;
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_outputs", 32'({bus.byte_ready, bus.im_we, busy, done, error, cpu_run}), 32'd0);
    chk("rst_addr", 32'(bus.im_addr), 32'd0);
    chk("rst_wdata", 32'(bus.im_wdata), 32'd0);
    clear_n = 1'b1;
    @(posedge clk);
    #1;

    // nominal two-word image, then the same image with a bad checksum
    w = {16'h1234, 16'hABCD};
    pulse_start();
    run_image(w, 8'h02, 1'b0, 2, 1'b0);
    pulse_start();
    run_image(w, 8'h02, 1'b1, 2, 1'b0);

    // illegal lengths
    pulse_start();
    run_image(w, 8'h00, 1'b0, 1, 1'b0);
    pulse_start();
    run_image(w, 8'h41, 1'b0, 1, 1'b0);

    // full-depth image, data equals address, valid held high throughout
    w = {};
    for (int i = 0; i < 64; i++) w.push_back(16'(i));
    pulse_start();
    run_image(w, 8'h40, 1'b0, 0, 1'b0);

    // random images: continuous valid vs random gaps
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 20);
      rand_words(w, n);
      bad = ($urandom_range(0, 3) == 0);
      pulse_start();
      run_image(w, 8'(n), bad, (k % 2 == 0) ? 0 : 3, 1'b0);
    end

    // reset after three of five words
    rand_words(w, 5);
    pulse_start();
    send_byte(8'h05, 1);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({6'(i), w[i]});
      send_byte(w[i][15:8], 1);
      send_byte(w[i][7:0], 1);
    end
    bus.byte_valid = 1'b0;
    for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(negedge clk);
    chk("pre_reset_writes", 32'(exp_q.size()), 32'd0);
    clear_n = 1'b0;
    #1;
    chk("midload_rst_outputs", 32'({bus.byte_ready, bus.im_we, busy, done, error, cpu_run}), 32'd0);
    chk("midload_rst_addr", 32'(bus.im_addr), 32'd0);
    chk("midload_rst_state", 32'(state_dbg), 32'd0);
    repeat (3) @(negedge clk);
    clear_n = 1'b1;
    @(posedge clk);
    #1;
    rand_words(w, 5);
    pulse_start();
    run_image(w, 8'h05, 1'b0, 2, 1'b0);

    // start during HI is ignored
    rand_words(w, 3);
    pulse_start();
    run_image(w, 8'h03, 1'b0, 1, 1'b1);

    // start from DONE drops cpu_run at once, then a new image overwrites from address 0
    @(negedge clk);
    chk("done_before_restart", 32'(cpu_run), 32'd1);
    @(posedge clk);
    #1;
    pulse_start();
    @(negedge clk);
    chk("restart_cpu_run", 32'(cpu_run), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    rand_words(w, 4);
    run_image(w, 8'h04, 1'b0, 2, 1'b0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
